// File: rtl/set_code_if.sv
// Keypad / code-status bundle for the set_code block.
// master drives the keypad side, slave is the set_code block itself.
interface set_code_if;
  logic        GO;
  logic [3:0]  BUTTON;
  logic        BPRESS;
  logic [3:0]  ENTER_BUTTON;
  logic [23:0] CODE;
  logic [2:0]  LENGTH;
  logic        BUSY;
  logic        DONE;
  logic        SUCCESS;

  modport master (
    output GO, BUTTON, BPRESS, ENTER_BUTTON,
    input  CODE, LENGTH, BUSY, DONE, SUCCESS
  );

  modport slave (
    input  GO, BUTTON, BPRESS, ENTER_BUTTON,
    output CODE, LENGTH, BUSY, DONE, SUCCESS
  );
endinterface

// File: rtl/set_code.sv
// Code-programming session: enter a 1..6 digit code, confirm it by re-entry,
// then commit it to CODE/LENGTH. Any entry/confirm error ends in FAIL.
module set_code #(
  parameter logic [23:0] DEFAULT_CODE   = 24'h004321,
  parameter logic [2:0]  DEFAULT_LENGTH = 3'd4
) (
  input logic        CLK,
  input logic        RST,
  set_code_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUFFER,
    S_ENTRY,
    S_OVERFLOW,
    S_CONFIRM,
    S_COMMIT,
    S_FAIL
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [23:0] r_shadow;
  logic [23:0] w_shadow_next;
  logic [2:0]  r_index;
  logic [2:0]  w_index_next;
  logic        r_mismatch;
  logic        w_mismatch_next;
  logic [2:0]  r_plen;
  logic [2:0]  w_plen_next;
  logic [23:0] r_code;
  logic [2:0]  r_length;
  logic        w_commit;

  logic        w_enter;
  logic        w_digit;
  logic [4:0]  w_shamt;
  logic [3:0]  w_cur_nibble;
  logic [23:0] w_keep_mask;

  assign w_enter = bus.BPRESS && (bus.BUTTON == bus.ENTER_BUTTON);
  assign w_digit = bus.BPRESS && (bus.BUTTON != bus.ENTER_BUTTON);
  assign w_shamt = {r_index, 2'b00};
  // Index 6/7 shifts the nibble out entirely; those cases already flag a mismatch.
  assign w_cur_nibble = 4'(r_shadow >> w_shamt);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_mask
      assign w_keep_mask[4*gi +: 4] = (3'(gi) < r_plen) ? 4'hF : 4'h0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shadow_next   = r_shadow;
    w_index_next    = r_index;
    w_mismatch_next = r_mismatch;
    w_plen_next     = r_plen;
    w_commit        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.GO) begin
          w_state_next = S_BUFFER;
        end
      end
      S_BUFFER: begin
        w_shadow_next   = '0;
        w_index_next    = '0;
        w_mismatch_next = 1'b0;
        w_state_next    = S_ENTRY;
      end
      S_ENTRY: begin
        if (w_enter) begin
          if (r_index == 3'd0) begin
            w_state_next = S_FAIL;
          end else begin
            w_plen_next  = r_index;
            w_index_next = '0;
            w_state_next = S_CONFIRM;
          end
        end else if (w_digit) begin
          if (r_index < 3'd6) begin
            w_shadow_next = (r_shadow & ~(24'hF << w_shamt)) | (24'(bus.BUTTON) << w_shamt);
            w_index_next  = r_index + 3'd1;
          end else begin
            w_state_next = S_OVERFLOW;
          end
        end
      end
      S_OVERFLOW: begin
        if (w_enter) begin
          w_state_next = S_FAIL;
        end
      end
      S_CONFIRM: begin
        if (w_enter) begin
          if (!r_mismatch && (r_index == r_plen)) begin
            w_commit     = 1'b1;
            w_state_next = S_COMMIT;
          end else begin
            w_state_next = S_FAIL;
          end
        end else if (w_digit) begin
          if ((r_index >= r_plen) || (bus.BUTTON != w_cur_nibble)) begin
            w_mismatch_next = 1'b1;
          end
          if (r_index != 3'd7) begin
            w_index_next = r_index + 3'd1;
          end
        end
      end
      S_COMMIT: w_state_next = S_IDLE;
      S_FAIL:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shadow   <= '0;
      r_index    <= '0;
      r_mismatch <= 1'b0;
      r_plen     <= '0;
      r_code     <= DEFAULT_CODE;
      r_length   <= DEFAULT_LENGTH;
    end else begin
      r_shadow   <= w_shadow_next;
      r_index    <= w_index_next;
      r_mismatch <= w_mismatch_next;
      r_plen     <= w_plen_next;
      if (w_commit) begin
        r_code   <= r_shadow & w_keep_mask;
        r_length <= r_plen;
      end
    end
  end

  assign bus.CODE    = r_code;
  assign bus.LENGTH  = r_length;
  assign bus.BUSY    = (r_state != S_IDLE);
  assign bus.DONE    = (r_state == S_COMMIT) || (r_state == S_FAIL);
  assign bus.SUCCESS = (r_state == S_COMMIT);

endmodule
